// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS main decoder: opcodes, ALU hints,
// FSM state encoding and the next-state rule. Optional macro: MC_MAINDEC_BNE_EN.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    TRAP    = 4'd12
  } state_t;

  // DECODE dispatches on the live opcode; MEMADR relies on the copy latched in DECODE.
  function automatic state_t next_state(input state_t st, input logic [5:0] op,
                                        input logic [5:0] op_latched, input logic mem_ready);
    state_t nxt;
    nxt = st;
    case (st)
      FETCH:   if (mem_ready) nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYPE:     nxt = EXECUTE;
          OP_BEQ:       nxt = BRANCH;
`ifdef MC_MAINDEC_BNE_EN
          OP_BNE:       nxt = BRANCH;
`endif
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JUMP;
          default:      nxt = TRAP;
        endcase
      end
      MEMADR:  nxt = (op_latched == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (mem_ready) nxt = MEMWB;
      MEMWR:   if (mem_ready) nxt = FETCH;
      EXECUTE: nxt = ALUWB;
      ADDIEX:  nxt = ADDIWB;
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: nxt = FETCH;
      TRAP:    nxt = TRAP;
      default: nxt = FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_maindec_outdec.sv
// Moore output decode for the main decoder FSM; strobes and illegal are gated by reset.
// Optional macro: MC_MAINDEC_BNE_EN (adds the latched-opcode input for bne).
module mc_maindec_outdec
  import mips_pkg::*;
#(
  parameter int ALUOPW = 2
) (
  input  state_t            state,
`ifdef MC_MAINDEC_BNE_EN
  input  logic [5:0]        opcode,
`endif
  input  logic              mem_ready,
  input  logic              reset_n,
  output logic              pcwrite,
  output logic              irwrite,
  output logic              memwrite,
  output logic              regwrite,
  output logic              iord,
  output logic              alusrca,
  output logic              regdst,
  output logic              memtoreg,
  output logic              branch,
  output logic [1:0]        alusrcb,
  output logic [1:0]        pcsrc,
  output logic [ALUOPW-1:0] aluop,
  output logic              bne,
  output logic              illegal
);

  logic       pcwrite_c, irwrite_c, memwrite_c, regwrite_c, illegal_c;
  logic [1:0] aluop_c;

  always_comb begin
    pcwrite_c  = 1'b0;
    irwrite_c  = 1'b0;
    memwrite_c = 1'b0;
    regwrite_c = 1'b0;
    illegal_c  = 1'b0;
    iord       = 1'b0;
    alusrca    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    branch     = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop_c    = ALUOP_ADD;
    case (state)
      FETCH: begin
        alusrcb   = 2'b01;
        irwrite_c = mem_ready;
        pcwrite_c = mem_ready;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWR: begin
        iord       = 1'b1;
        memwrite_c = mem_ready;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_c = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop_c = ALUOP_FUNCT;
      end
      ALUWB: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop_c = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB:  regwrite_c = 1'b1;
      JUMP: begin
        pcsrc     = 2'b10;
        pcwrite_c = 1'b1;
      end
      TRAP:    illegal_c = 1'b1;
      default: ;
    endcase
  end

`ifdef MC_MAINDEC_BNE_EN
  assign bne = (state == BRANCH) && (opcode == OP_BNE);
`else
  assign bne = 1'b0;
`endif

  // Reset must suppress the FETCH strobes combinationally, not just via the state register.
  assign pcwrite  = pcwrite_c  & reset_n;
  assign irwrite  = irwrite_c  & reset_n;
  assign memwrite = memwrite_c & reset_n;
  assign regwrite = regwrite_c & reset_n;
  assign illegal  = illegal_c  & reset_n;
  assign aluop    = ALUOPW'(aluop_c);

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main decoder: state and opcode registers around the output decode.
// Optional macro: MC_MAINDEC_BNE_EN enables the bne opcode.
module mc_maindec
  import mips_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [OPW-1:0]    op,
  input  logic              mem_ready,
  output logic              pcwrite,
  output logic              irwrite,
  output logic              memwrite,
  output logic              regwrite,
  output logic              iord,
  output logic              alusrca,
  output logic              regdst,
  output logic              memtoreg,
  output logic              branch,
  output logic [1:0]        alusrcb,
  output logic [1:0]        pcsrc,
  output logic [ALUOPW-1:0] aluop,
  output logic              bne,
  output logic              illegal,
  output logic [3:0]        state_o
);

  state_t         state_reg;
  logic [OPW-1:0] opcode_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= FETCH;
      opcode_reg <= '0;
    end else begin
      state_reg <= next_state(state_reg, op, opcode_reg, mem_ready);
      if (state_reg == DECODE) opcode_reg <= op;
    end
  end

  assign state_o = state_reg;

  mc_maindec_outdec #(.ALUOPW(ALUOPW)) u_outdec (
    .state     (state_reg),
`ifdef MC_MAINDEC_BNE_EN
    .opcode    (opcode_reg),
`endif
    .mem_ready (mem_ready),
    .reset_n   (reset_n),
    .pcwrite   (pcwrite),
    .irwrite   (irwrite),
    .memwrite  (memwrite),
    .regwrite  (regwrite),
    .iord      (iord),
    .alusrca   (alusrca),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .branch    (branch),
    .alusrcb   (alusrcb),
    .pcsrc     (pcsrc),
    .aluop     (aluop),
    .bne       (bne),
    .illegal   (illegal)
  );

endmodule

// File: tb/tb_mc_maindec.sv
// Self-checking bench for mc_maindec: directed and random instruction streams against
// a per-instruction state-path model and the per-state control table.
`timescale 1ns/1ps
module tb_mc_maindec;
  import mips_pkg::*;

  localparam int AW = 3;  // wider aluop so the zero upper bit is observable

  logic          clk = 1'b0;
  logic          reset_n;
  logic [5:0]    op;
  logic          mem_ready;
  logic          pcwrite, irwrite, memwrite, regwrite;
  logic          iord, alusrca, regdst, memtoreg, branch;
  logic [1:0]    alusrcb, pcsrc;
  logic [AW-1:0] aluop;
  logic          bne, illegal;
  logic [3:0]    state_o;

  typedef struct packed {
    logic          pcwrite, irwrite, memwrite, regwrite;
    logic          iord, alusrca, regdst, memtoreg, branch;
    logic [1:0]    alusrcb, pcsrc;
    logic [AW-1:0] aluop;
    logic          bne, illegal;
  } ctl_t;

  int   checks   = 0;
  int   failures = 0;
  ctl_t obs;

  always #5 clk = ~clk;

  mc_maindec #(.OPW(6), .ALUOPW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .iord(iord), .alusrca(alusrca), .regdst(regdst), .memtoreg(memtoreg), .branch(branch),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .bne(bne), .illegal(illegal),
    .state_o(state_o)
  );

  assign obs = {pcwrite, irwrite, memwrite, regwrite, iord, alusrca, regdst, memtoreg,
                branch, alusrcb, pcsrc, aluop, bne, illegal};

  // Control word each state must show, straight from the per-state output table.
  function automatic ctl_t spec_ctl(input state_t s, input logic rdy, input logic [5:0] opc);
    ctl_t e;
    e = '0;
    case (s)
      FETCH:   begin e.alusrcb = 2'b01; e.irwrite = rdy; e.pcwrite = rdy; end
      DECODE:  e.alusrcb = 2'b11;
      MEMADR:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      MEMRD:   e.iord = 1'b1;
      MEMWR:   begin e.iord = 1'b1; e.memwrite = rdy; end
      MEMWB:   begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
      EXECUTE: begin e.alusrca = 1'b1; e.aluop = 3'b010; end
      ALUWB:   begin e.regdst = 1'b1; e.regwrite = 1'b1; end
      BRANCH: begin
        e.alusrca = 1'b1; e.aluop = 3'b001; e.pcsrc = 2'b01; e.branch = 1'b1;
`ifdef MC_MAINDEC_BNE_EN
        e.bne = (opc == 6'b000101);
`endif
      end
      ADDIEX:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      ADDIWB:  e.regwrite = 1'b1;
      JUMP:    begin e.pcsrc = 2'b10; e.pcwrite = 1'b1; end
      TRAP:    e.illegal = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  // Under reset: FETCH selects, every strobe and illegal forced low.
  function automatic ctl_t reset_ctl();
    ctl_t e;
    e = '0;
    e.alusrcb = 2'b01;
    return e;
  endfunction

  task automatic check(input string tag, input state_t s_exp, input ctl_t c_exp);
    checks++;
    assert (state_o === s_exp) else begin
      failures++;
      $error("FAIL %s state got=%0d want=%0d", tag, state_o, s_exp);
    end
    checks++;
    assert (obs === c_exp) else begin
      failures++;
      $error("FAIL %s ctl got=%h want=%h", tag, obs, c_exp);
    end
  endtask

  task automatic step(input state_t s, input logic rdy, input logic [5:0] opdrv,
                      input logic [5:0] opc, input string tag);
    @(negedge clk);
    op        = opdrv;
    mem_ready = rdy;
    #1;
    check(tag, s, spec_ctl(s, rdy, opc));
  endtask

  // Reset asserted mid-cycle; outputs must react before any clock edge.
  task automatic reset_pulse(input string tag);
    #2;
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    #1;
    check({tag, "_async"}, FETCH, reset_ctl());
    @(posedge clk);
    #1;
    check({tag, "_held"}, FETCH, reset_ctl());
    @(negedge clk);
    mem_ready = 1'b0;
    reset_n   = 1'b1;
  endtask

  // waits < 0: random 0..2 wait cycles per memory phase; otherwise exact count (FETCH none).
  task automatic run_instr(input logic [5:0] opc, input int waits, input bit abort_memrd);
    state_t path[$];
    state_t s;
    int     nw;
    path = {FETCH, DECODE};
    case (opc)
      6'b100011: path = {path, MEMADR, MEMRD, MEMWB};
      6'b101011: path = {path, MEMADR, MEMWR};
      6'b000000: path = {path, EXECUTE, ALUWB};
      6'b000100: path = {path, BRANCH};
`ifdef MC_MAINDEC_BNE_EN
      6'b000101: path = {path, BRANCH};
`endif
      6'b001000: path = {path, ADDIEX, ADDIWB};
      6'b000010: path = {path, JUMP};
      default:   path = {path, TRAP};
    endcase
    $display("instr op=%b waits=%0d abort=%0d path_len=%0d", opc, waits, abort_memrd, path.size());
    foreach (path[i]) begin
      s = path[i];
      if (s == FETCH || s == MEMRD || s == MEMWR) begin
        if (waits < 0) nw = $urandom_range(0, 2);
        else           nw = (s == FETCH) ? 0 : waits;
        if (abort_memrd && s == MEMRD && nw == 0) nw = 1;
        for (int w = 0; w < nw; w++) step(s, 1'b0, 6'($urandom), opc, s.name());
        if (abort_memrd && s == MEMRD) begin
          reset_pulse("abort_memrd");
          return;
        end
        step(s, 1'b1, 6'($urandom), opc, s.name());
      end else if (s == TRAP) begin
        for (int t = 0; t < 12; t++) step(TRAP, 1'($urandom), 6'($urandom), opc, "trap_sticky");
        reset_pulse("trap_clear");
      end else begin
        step(s, 1'($urandom), (s == DECODE) ? opc : 6'($urandom), opc, s.name());
      end
    end
  endtask

  logic [5:0] pool [9];

  initial begin
    pool = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
             6'b001000, 6'b000010, 6'b111111, 6'b001101};
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    op        = 6'($urandom);
    repeat (2) @(posedge clk);
    #1;
    check("reset", FETCH, reset_ctl());
    @(negedge clk);
    reset_n   = 1'b1;
    mem_ready = 1'b0;

    run_instr(6'b100011, 0, 1'b0);   // LW, no waits
    run_instr(6'b101011, 3, 1'b0);   // SW, three wait cycles in MEMWR
    run_instr(6'b000100, 0, 1'b0);   // BEQ
    run_instr(6'b000101, 0, 1'b0);   // BNE (or trap when compiled out)
    run_instr(6'b001000, 1, 1'b0);   // ADDI with op scrambled after DECODE
    run_instr(6'b000000, 0, 1'b0);   // R-type
    run_instr(6'b000010, 0, 1'b0);   // J
    run_instr(6'b111111, 0, 1'b0);   // illegal -> TRAP
    run_instr(6'b100011, 2, 1'b1);   // LW aborted in MEMRD
    run_instr(6'b100011, 1, 1'b0);   // resumes cleanly

    for (int n = 0; n < 40; n++) run_instr(pool[$urandom_range(0, 8)], -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
